// File: rtl/csr_hpm_counters.sv
// Machine hardware performance-monitor CSR block: selectable-event counters, inhibit mask, overflow interrupt.
// Latency: reads are combinational from register state; writes and event counts land on the next clk edge.
// Backpressure: none; every CSR access is accepted in the cycle it is presented.
module csr_hpm_counters #(
    parameter int COUNTER_COUNT = 4,
    parameter int COUNTER_WIDTH = 64,
    parameter int EVENT_COUNT   = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   csrWriteEnable,
    input  logic                   csrReadEnable,
    input  logic [11:0]            csrWriteAddress,
    input  logic [11:0]            csrReadAddress,
    input  logic [31:0]            csrWriteData,
    output logic [31:0]            csrReadData,
    output logic                   csrRequestOutput,
    input  logic [EVENT_COUNT-1:0] events,
    output logic                   overflowInterrupt
);

    localparam int          HI_W              = COUNTER_WIDTH - 32;
    localparam logic [11:0] ADDR_INHIBIT      = 12'h320;
    localparam logic [11:0] ADDR_EVENT_BASE   = 12'h323;
    localparam logic [11:0] ADDR_CNT_LO_BASE  = 12'hB03;
    localparam logic [11:0] ADDR_CNT_HI_BASE  = 12'hB83;
    localparam logic [11:0] ADDR_UCNT_LO_BASE = 12'hC03;
    localparam logic [11:0] ADDR_UCNT_HI_BASE = 12'hC83;
    localparam logic [4:0]  SEL_MAX           = 5'(EVENT_COUNT);

    // Architectural state
    logic [COUNTER_WIDTH-1:0] cnt_q [COUNTER_COUNT];
    logic [COUNTER_WIDTH-1:0] cnt_d [COUNTER_COUNT];
    logic [4:0]               sel_q [COUNTER_COUNT];
    logic [4:0]               sel_d [COUNTER_COUNT];
    logic [COUNTER_COUNT-1:0] ovie_q, ovie_d;
    logic [COUNTER_COUNT-1:0] of_q, of_d;
    logic [COUNTER_COUNT-1:0] inhibit_q, inhibit_d;

    // Per-counter decode of this cycle's write and count activity
    logic [COUNTER_COUNT-1:0] wr_lo, wr_hi, wr_evt, inc, wrap;
    logic                     wr_inhibit;
    logic [31:0]              evt_ext;
    logic [4:0]               wr_sel;

    logic                     rd_hit;
    logic [31:0]              rd_data;

    // Bit 0 is tied low so SEL=0 naturally selects "no event"
    always_comb begin
        evt_ext                  = '0;
        evt_ext[EVENT_COUNT:1]   = events;
    end

    // Out-of-range selector writes collapse to "no event"
    assign wr_sel     = (csrWriteData[4:0] > SEL_MAX) ? 5'd0 : csrWriteData[4:0];
    assign wr_inhibit = csrWriteEnable && (csrWriteAddress == ADDR_INHIBIT);

    // Decode writes and detect increments/wraps; a counter write overrides its own increment
    always_comb begin
        wr_lo  = '0;
        wr_hi  = '0;
        wr_evt = '0;
        inc    = '0;
        wrap   = '0;
        for (int i = 0; i < COUNTER_COUNT; i++) begin
            wr_lo[i]  = csrWriteEnable && (csrWriteAddress == ADDR_CNT_LO_BASE + 12'(i));
            wr_hi[i]  = csrWriteEnable && (csrWriteAddress == ADDR_CNT_HI_BASE + 12'(i));
            wr_evt[i] = csrWriteEnable && (csrWriteAddress == ADDR_EVENT_BASE + 12'(i));
            inc[i]    = evt_ext[sel_q[i]] && !inhibit_q[i] && !wr_lo[i] && !wr_hi[i];
            wrap[i]   = inc[i] && (&cnt_q[i]);
        end
    end

    // Next-state for counters, selectors and flags; hardware overflow wins over a software OF clear
    always_comb begin
        inhibit_d = inhibit_q;
        ovie_d    = ovie_q;
        of_d      = of_q | wrap;
        if (wr_inhibit) begin
            inhibit_d = csrWriteData[3 +: COUNTER_COUNT];
        end
        for (int i = 0; i < COUNTER_COUNT; i++) begin
            cnt_d[i] = cnt_q[i];
            sel_d[i] = sel_q[i];
            if (wr_lo[i]) begin
                cnt_d[i][31:0] = csrWriteData;
            end else if (wr_hi[i]) begin
                cnt_d[i][COUNTER_WIDTH-1:32] = csrWriteData[HI_W-1:0];
            end else if (inc[i]) begin
                cnt_d[i] = cnt_q[i] + COUNTER_WIDTH'(1);
            end
            if (wr_evt[i]) begin
                sel_d[i]  = wr_sel;
                ovie_d[i] = csrWriteData[30];
                of_d[i]   = csrWriteData[31] | wrap[i];
            end
        end
    end

    // State registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < COUNTER_COUNT; i++) begin
                cnt_q[i] <= '0;
                sel_q[i] <= '0;
            end
            ovie_q    <= '0;
            of_q      <= '0;
            inhibit_q <= '0;
        end else begin
            for (int i = 0; i < COUNTER_COUNT; i++) begin
                cnt_q[i] <= cnt_d[i];
                sel_q[i] <= sel_d[i];
            end
            ovie_q    <= ovie_d;
            of_q      <= of_d;
            inhibit_q <= inhibit_d;
        end
    end

    // Read mux over current state; user-mode shadows alias the machine counters
    always_comb begin
        rd_hit  = 1'b0;
        rd_data = '0;
        if (csrReadAddress == ADDR_INHIBIT) begin
            rd_hit  = 1'b1;
            rd_data = 32'({inhibit_q, 3'b000});
        end
        for (int i = 0; i < COUNTER_COUNT; i++) begin
            if ((csrReadAddress == ADDR_CNT_LO_BASE + 12'(i)) ||
                (csrReadAddress == ADDR_UCNT_LO_BASE + 12'(i))) begin
                rd_hit  = 1'b1;
                rd_data = cnt_q[i][31:0];
            end
            if ((csrReadAddress == ADDR_CNT_HI_BASE + 12'(i)) ||
                (csrReadAddress == ADDR_UCNT_HI_BASE + 12'(i))) begin
                rd_hit  = 1'b1;
                rd_data = 32'(cnt_q[i][COUNTER_WIDTH-1:32]);
            end
            if (csrReadAddress == ADDR_EVENT_BASE + 12'(i)) begin
                rd_hit  = 1'b1;
                rd_data = {of_q[i], ovie_q[i], 25'b0, sel_q[i]};
            end
        end
    end

    assign csrRequestOutput  = csrReadEnable && rd_hit;
    assign csrReadData       = csrRequestOutput ? rd_data : 32'd0;
    assign overflowInterrupt = |(of_q & ovie_q);

endmodule

// File: tb/tb_csr_hpm_counters.sv
// Directed bench for csr_hpm_counters built with 4 counters, 40-bit width, 8 events.
// Each vector is one clock cycle: inputs driven after the edge, outputs compared at the falling edge.
// Table-driven main flow plus a hand-written asynchronous reset sequence.
module tb_csr_hpm_counters;

    typedef struct {
        logic        we;
        logic [11:0] wa;
        logic [31:0] wd;
        logic        re;
        logic [11:0] ra;
        logic [7:0]  ev;
        logic [31:0] rd;
        logic        req;
        logic        irq;
        string       name;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        csrWriteEnable;
    logic        csrReadEnable;
    logic [11:0] csrWriteAddress;
    logic [11:0] csrReadAddress;
    logic [31:0] csrWriteData;
    logic [31:0] csrReadData;
    logic        csrRequestOutput;
    logic [7:0]  events;
    logic        overflowInterrupt;

    int n_vec = 0;
    int n_bad = 0;
    vec_t tbl1[$];
    vec_t tbl2[$];

    always #5 clk = ~clk;

    csr_hpm_counters #(
        .COUNTER_COUNT(4),
        .COUNTER_WIDTH(40),
        .EVENT_COUNT  (8)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .csrWriteEnable   (csrWriteEnable),
        .csrReadEnable    (csrReadEnable),
        .csrWriteAddress  (csrWriteAddress),
        .csrReadAddress   (csrReadAddress),
        .csrWriteData     (csrWriteData),
        .csrReadData      (csrReadData),
        .csrRequestOutput (csrRequestOutput),
        .events           (events),
        .overflowInterrupt(overflowInterrupt)
    );

    function automatic vec_t mk(input logic we, input logic [11:0] wa, input logic [31:0] wd,
                                input logic re, input logic [11:0] ra, input logic [7:0] ev,
                                input logic [31:0] rd, input logic req, input logic irq,
                                input string name);
        vec_t v;
        v.we = we; v.wa = wa; v.wd = wd; v.re = re; v.ra = ra; v.ev = ev;
        v.rd = rd; v.req = req; v.irq = irq; v.name = name;
        return v;
    endfunction

    task automatic check(input logic [31:0] rd, input logic req, input logic irq, input string name);
        n_vec++;
        if (csrReadData !== rd || csrRequestOutput !== req || overflowInterrupt !== irq) begin
            n_bad++;
            $display("FAIL %s: got rdata=%h req=%b irq=%b, want rdata=%h req=%b irq=%b",
                     name, csrReadData, csrRequestOutput, overflowInterrupt, rd, req, irq);
        end
    endtask

    task automatic apply(input vec_t v);
        csrWriteEnable  = v.we;
        csrWriteAddress = v.wa;
        csrWriteData    = v.wd;
        csrReadEnable   = v.re;
        csrReadAddress  = v.ra;
        events          = v.ev;
        @(negedge clk);
        check(v.rd, v.req, v.irq, v.name);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0;
        csrWriteEnable = 1'b0; csrReadEnable = 1'b0;
        csrWriteAddress = '0; csrReadAddress = '0; csrWriteData = '0; events = '0;

        // Part 1: reset state, event counting, 40-bit wrap and interrupt
        tbl1.push_back(mk(0, 12'h000, 32'h0,         1, 12'hB03, 8'h00, 32'h0,         1, 0, "rst_cnt3"));
        tbl1.push_back(mk(0, 12'h000, 32'h0,         1, 12'h320, 8'h00, 32'h0,         1, 0, "rst_inhibit"));
        tbl1.push_back(mk(1, 12'h323, 32'h2,         1, 12'h323, 8'h00, 32'h0,         1, 0, "sel_wr_prewrite"));
        tbl1.push_back(mk(0, 12'h000, 32'h0,         1, 12'h323, 8'h03, 32'h2,         1, 0, "sel_rd"));
        tbl1.push_back(mk(0, 12'h000, 32'h0,         1, 12'hB03, 8'h02, 32'h1,         1, 0, "cnt_1"));
        tbl1.push_back(mk(0, 12'h000, 32'h0,         1, 12'hB03, 8'h03, 32'h2,         1, 0, "cnt_2"));
        tbl1.push_back(mk(0, 12'h000, 32'h0,         1, 12'hB03, 8'h02, 32'h3,         1, 0, "cnt_3"));
        tbl1.push_back(mk(0, 12'h000, 32'h0,         1, 12'hB03, 8'h03, 32'h4,         1, 0, "cnt_4"));
        tbl1.push_back(mk(0, 12'h000, 32'h0,         1, 12'hB03, 8'h01, 32'h5,         1, 0, "cnt_5"));
        tbl1.push_back(mk(0, 12'h000, 32'h0,         1, 12'hB83, 8'h00, 32'h0,         1, 0, "cnth_0"));
        tbl1.push_back(mk(1, 12'hB03, 32'hFFFFFFFE,  1, 12'hB03, 8'h00, 32'h5,         1, 0, "wr_lo_prewrite"));
        tbl1.push_back(mk(1, 12'hB83, 32'hFFFFFFFF,  1, 12'hB03, 8'h00, 32'hFFFFFFFE,  1, 0, "wr_hi_keeps_lo"));
        tbl1.push_back(mk(1, 12'h323, 32'h40000002,  1, 12'hB83, 8'h00, 32'h000000FF,  1, 0, "hi_40bit_mask"));
        tbl1.push_back(mk(0, 12'h000, 32'h0,         1, 12'hB03, 8'h02, 32'hFFFFFFFE,  1, 0, "pre_wrap_1"));
        tbl1.push_back(mk(0, 12'h000, 32'h0,         1, 12'hB03, 8'h02, 32'hFFFFFFFF,  1, 0, "pre_wrap_2"));
        tbl1.push_back(mk(0, 12'h000, 32'h0,         1, 12'hB03, 8'h00, 32'h0,         1, 1, "wrap_lo"));
        tbl1.push_back(mk(0, 12'h000, 32'h0,         1, 12'hB83, 8'h00, 32'h0,         1, 1, "wrap_hi"));
        tbl1.push_back(mk(0, 12'h000, 32'h0,         1, 12'h323, 8'h00, 32'hC0000002,  1, 1, "of_set"));
        tbl1.push_back(mk(1, 12'h323, 32'h40000002,  1, 12'h323, 8'h02, 32'hC0000002,  1, 1, "of_clr_prewrite"));
        tbl1.push_back(mk(0, 12'h000, 32'h0,         1, 12'h323, 8'h00, 32'h40000002,  1, 0, "of_clr_irq_drop"));
        tbl1.push_back(mk(0, 12'h000, 32'h0,         1, 12'hB03, 8'h00, 32'h1,         1, 0, "count_after_wrap"));
        tbl1.push_back(mk(1, 12'h323, 32'hC0000000,  1, 12'h323, 8'h00, 32'h40000002,  1, 0, "sw_of_set"));
        tbl1.push_back(mk(0, 12'h000, 32'h0,         1, 12'h323, 8'h00, 32'hC0000000,  1, 1, "sw_of_irq"));

        // Part 2: inhibit, write-suppressed increment, WARL selector, shadows, unmapped addresses
        tbl2.push_back(mk(1, 12'h323, 32'h2,         1, 12'h323, 8'h00, 32'h0,         1, 0, "sel3_after_rst"));
        tbl2.push_back(mk(1, 12'h324, 32'h2,         1, 12'h324, 8'h00, 32'h0,         1, 0, "sel4_wr"));
        tbl2.push_back(mk(1, 12'h320, 32'h8,         1, 12'h320, 8'h02, 32'h0,         1, 0, "inh_prewrite"));
        tbl2.push_back(mk(0, 12'h000, 32'h0,         1, 12'h320, 8'h02, 32'h8,         1, 0, "inh_rd"));
        tbl2.push_back(mk(0, 12'h000, 32'h0,         1, 12'hB03, 8'h02, 32'h1,         1, 0, "inh_frozen3"));
        tbl2.push_back(mk(0, 12'h000, 32'h0,         1, 12'hB04, 8'h02, 32'h3,         1, 0, "inh_cnt4_runs"));
        tbl2.push_back(mk(0, 12'h000, 32'h0,         1, 12'hB03, 8'h00, 32'h1,         1, 0, "inh_still_frozen"));
        tbl2.push_back(mk(1, 12'h320, 32'hFFFFFFFF,  1, 12'h320, 8'h00, 32'h8,         1, 0, "inh_all_prewrite"));
        tbl2.push_back(mk(1, 12'h320, 32'h0,         1, 12'h320, 8'h00, 32'h78,        1, 0, "inh_impl_bits"));
        tbl2.push_back(mk(0, 12'h000, 32'h0,         1, 12'h320, 8'h00, 32'h0,         1, 0, "inh_cleared"));
        tbl2.push_back(mk(1, 12'hB03, 32'h100,       1, 12'hB03, 8'h02, 32'h1,         1, 0, "wr_cnt_ev_hi"));
        tbl2.push_back(mk(0, 12'h000, 32'h0,         1, 12'hB03, 8'h02, 32'h100,       1, 0, "wr_cnt_exact"));
        tbl2.push_back(mk(0, 12'h000, 32'h0,         1, 12'hB03, 8'h00, 32'h101,       1, 0, "wr_cnt_plus1"));
        tbl2.push_back(mk(1, 12'h323, 32'h1F,        1, 12'hB03, 8'h02, 32'h101,       1, 0, "sel31_old_sel"));
        tbl2.push_back(mk(0, 12'h000, 32'h0,         1, 12'h323, 8'hFF, 32'h0,         1, 0, "sel31_warl"));
        tbl2.push_back(mk(0, 12'h000, 32'h0,         1, 12'hB03, 8'hFF, 32'h102,       1, 0, "sel31_no_cnt"));
        tbl2.push_back(mk(0, 12'h000, 32'h0,         1, 12'hC03, 8'hFF, 32'h102,       1, 0, "shadow_lo"));
        tbl2.push_back(mk(1, 12'hC03, 32'h55,        1, 12'hC03, 8'hFF, 32'h102,       1, 0, "shadow_wr"));
        tbl2.push_back(mk(0, 12'h000, 32'h0,         1, 12'hB03, 8'h00, 32'h102,       1, 0, "shadow_wr_ignored"));
        tbl2.push_back(mk(0, 12'h000, 32'h0,         1, 12'hC83, 8'h00, 32'h0,         1, 0, "shadow_hi"));
        tbl2.push_back(mk(1, 12'h323, 32'h8,         1, 12'hB03, 8'h00, 32'h102,       1, 0, "sel8_wr"));
        tbl2.push_back(mk(0, 12'h000, 32'h0,         1, 12'h323, 8'h80, 32'h8,         1, 0, "sel8_rd"));
        tbl2.push_back(mk(0, 12'h000, 32'h0,         1, 12'hB03, 8'h00, 32'h103,       1, 0, "sel8_counts"));
        tbl2.push_back(mk(1, 12'h323, 32'h9,         1, 12'h323, 8'h00, 32'h8,         1, 0, "sel9_prewrite"));
        tbl2.push_back(mk(0, 12'h000, 32'h0,         1, 12'h323, 8'h00, 32'h0,         1, 0, "sel9_warl"));
        tbl2.push_back(mk(0, 12'h000, 32'h0,         1, 12'hB07, 8'h00, 32'h0,         0, 0, "idx_oob_lo"));
        tbl2.push_back(mk(0, 12'h000, 32'h0,         1, 12'hC07, 8'h00, 32'h0,         0, 0, "idx_oob_shadow"));
        tbl2.push_back(mk(0, 12'h000, 32'h0,         1, 12'h321, 8'h00, 32'h0,         0, 0, "unmapped_321"));
        tbl2.push_back(mk(0, 12'h000, 32'h0,         0, 12'hB03, 8'h00, 32'h0,         0, 0, "no_read_en"));
        tbl2.push_back(mk(1, 12'hB07, 32'h1234,      1, 12'hB03, 8'h00, 32'h103,       1, 0, "oob_write"));
        tbl2.push_back(mk(0, 12'h000, 32'h0,         1, 12'h324, 8'h00, 32'h2,         1, 0, "last_counter_evt"));

        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;

        foreach (tbl1[k]) apply(tbl1[k]);

        // Asynchronous reset asserted mid-cycle with an interrupt pending and the event high
        csrWriteEnable = 1'b0;
        csrReadEnable  = 1'b1;
        csrReadAddress = 12'hB03;
        events         = 8'h02;
        #2 rst = 1'b0;
        #1 check(32'h0, 1'b1, 1'b0, "async_rst_cnt");
        csrReadAddress = 12'h323;
        #1 check(32'h0, 1'b1, 1'b0, "async_rst_evt");
        csrReadAddress = 12'hB83;
        #1 check(32'h0, 1'b1, 1'b0, "async_rst_cnth");
        @(posedge clk);
        #1 csrReadAddress = 12'hB03;
        #1 check(32'h0, 1'b1, 1'b0, "rst_held_cnt");
        csrReadEnable = 1'b0;
        #1 check(32'h0, 1'b0, 1'b0, "rst_req_follows");
        rst    = 1'b1;
        events = 8'h00;
        @(posedge clk);
        #1;

        foreach (tbl2[k]) apply(tbl2[k]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
